// File: rtl/mouse_packet_decoder.sv
// PS/2 stream-mode packet decoder: gathers status/dX/dY bytes from the byte
// receiver, validates them and tracks a clamped absolute cursor position.
module mouse_packet_decoder #(
  parameter int X_MAX     = 160,
  parameter int Y_MAX     = 120,
  parameter int X_INIT    = 80,
  parameter int Y_INIT    = 60,
  parameter int T_TIMEOUT = 200000
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       ENABLE,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_IN,
  input  logic [1:0] BYTE_ERROR_CODE_IN,
  input  logic       BYTE_READY_IN,
  output logic [7:0] MOUSE_STATUS,
  output logic [8:0] MOUSE_DX,
  output logic [8:0] MOUSE_DY,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic       PACKET_VALID,
  output logic       PACKET_ERROR
);

  localparam int CW = $clog2(T_TIMEOUT + 1);
  localparam logic signed [9:0] X_HI = 10'(X_MAX - 1);
  localparam logic signed [9:0] Y_HI = 10'(Y_MAX - 1);

  typedef enum logic [2:0] {IDLE, WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

  state_t          state, nxt;
  logic [CW-1:0]   tmo_cnt;
  logic            tmo, err_evt, acc_b0, acc_b1, acc_b2;
  logic [7:0]      st_q, dx_b, dy_b;
  logic [8:0]      dx_w, dy_w;
  logic signed [9:0] x_sum, y_sum;
  logic [7:0]      x_nxt, y_nxt;

  assign tmo = (tmo_cnt == CW'(T_TIMEOUT));

  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) state <= IDLE;
    else         state <= nxt;

  // ENABLE low wins over everything, dropping any partial packet silently.
  always_comb begin
    nxt     = state;
    err_evt = 1'b0;
    acc_b0  = 1'b0;
    acc_b1  = 1'b0;
    acc_b2  = 1'b0;
    if (!ENABLE) nxt = IDLE;
    else begin
      case (state)
        IDLE: nxt = WAIT_B0;
        WAIT_B0:
          if (BYTE_READY_IN) begin
            if ((|BYTE_ERROR_CODE_IN) || !BYTE_IN[3]) err_evt = 1'b1;
            else begin acc_b0 = 1'b1; nxt = WAIT_B1; end
          end
        WAIT_B1:
          if (BYTE_READY_IN) begin
            if (|BYTE_ERROR_CODE_IN) begin err_evt = 1'b1; nxt = WAIT_B0; end
            else begin acc_b1 = 1'b1; nxt = WAIT_B2; end
          end else if (tmo) begin err_evt = 1'b1; nxt = WAIT_B0; end
        WAIT_B2:
          if (BYTE_READY_IN) begin
            if (|BYTE_ERROR_CODE_IN) begin err_evt = 1'b1; nxt = WAIT_B0; end
            else begin acc_b2 = 1'b1; nxt = UPDATE; end
          end else if (tmo) begin err_evt = 1'b1; nxt = WAIT_B0; end
        UPDATE:  nxt = WAIT_B0;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    READ_ENABLE = (state == WAIT_B0) || (state == WAIT_B1) || (state == WAIT_B2);
  end

  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) tmo_cnt <= '0;
    else if (acc_b0 || acc_b1 || acc_b2 || !((state == WAIT_B1) || (state == WAIT_B2)))
      tmo_cnt <= '0;
    else if (!tmo) tmo_cnt <= tmo_cnt + 1'b1;

  // Overflow saturates the delta to the 9-bit extreme matching its sign.
  always_comb begin
    dx_w  = st_q[6] ? (st_q[4] ? 9'h100 : 9'h0FF) : {st_q[4], dx_b};
    dy_w  = st_q[7] ? (st_q[5] ? 9'h100 : 9'h0FF) : {st_q[5], dy_b};
    x_sum = $signed({2'b00, MOUSE_X}) + $signed({dx_w[8], dx_w});
    y_sum = $signed({2'b00, MOUSE_Y}) - $signed({dy_w[8], dy_w});
    x_nxt = x_sum[9] ? 8'd0 : ((x_sum > X_HI) ? X_HI[7:0] : x_sum[7:0]);
    y_nxt = y_sum[9] ? 8'd0 : ((y_sum > Y_HI) ? Y_HI[7:0] : y_sum[7:0]);
  end

  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      st_q <= '0;
      dx_b <= '0;
      dy_b <= '0;
    end else begin
      if (acc_b0) st_q <= BYTE_IN;
      if (acc_b1) dx_b <= BYTE_IN;
      if (acc_b2) dy_b <= BYTE_IN;
    end

  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      MOUSE_STATUS <= '0;
      MOUSE_DX     <= '0;
      MOUSE_DY     <= '0;
      MOUSE_X      <= 8'(X_INIT);
      MOUSE_Y      <= 8'(Y_INIT);
      PACKET_VALID <= 1'b0;
      PACKET_ERROR <= 1'b0;
    end else begin
      PACKET_VALID <= (state == UPDATE);
      PACKET_ERROR <= err_evt;
      if (state == UPDATE) begin
        MOUSE_STATUS <= st_q;
        MOUSE_DX     <= dx_w;
        MOUSE_DY     <= dy_w;
        MOUSE_X      <= x_nxt;
        MOUSE_Y      <= y_nxt;
      end
    end

endmodule
